// File: rtl/rf_pkg.sv
// Shared definitions for the regfile_sb register file: write-source select codes and default widths.
package rf_pkg;

  localparam int unsigned RF_DATA_W = 8;
  localparam int unsigned RF_ADDR_W = 3;

  localparam logic [2:0] SEL_A      = 3'b000;
  localparam logic [2:0] SEL_B      = 3'b001;
  localparam logic [2:0] SEL_OR2    = 3'b010;
  localparam logic [2:0] SEL_ALU    = 3'b011;
  localparam logic [2:0] SEL_SP_ACC = 3'b100;
  localparam logic [2:0] SEL_B_ACC  = 3'b101;
  localparam logic [2:0] SEL_MEM    = 3'b110;
  localparam logic [2:0] SEL_NONE   = 3'b111;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-load scoreboard and read-hazard detection for regfile_sb.
module rf_scoreboard #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 set_en,
  input  logic [ADDR_W-1:0]    set_seg,
  input  logic                 clr_en,
  input  logic [ADDR_W-1:0]    clr_seg,
  input  logic [ADDR_W-1:0]    rd_seg_A,
  input  logic                 rd_en_A,
  input  logic [ADDR_W-1:0]    rd_seg_B,
  input  logic                 rd_en_B,
  output logic [2**ADDR_W-1:0] pend,
  output logic                 stall
);

  logic [2**ADDR_W-1:0] set_mask;
  logic [2**ADDR_W-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_seg] = 1'b1;
    if (clr_en) clr_mask[clr_seg] = 1'b1;
  end

  // Set is OR'd in after the clear so a new load issued to the same index stays outstanding.
  always_ff @(posedge clk) begin
    if (clr) pend <= '0;
    else     pend <= (pend & ~clr_mask) | set_mask;
  end

  always_comb begin
    stall = (rd_en_A & pend[rd_seg_A]) | (rd_en_B & pend[rd_seg_B]);
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with source mux, load-writeback port, two registered reads and hazard scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = RF_DATA_W,
  parameter int unsigned ADDR_W  = RF_ADDR_W,
  parameter int unsigned ACC_IDX = 0
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we,
  input  logic [2:0]           mux_sel,
  input  logic [ADDR_W-1:0]    write_seg,
  input  logic [DATA_W-1:0]    A_in,
  input  logic [DATA_W-1:0]    B_in,
  input  logic [DATA_W-1:0]    OR2,
  input  logic [DATA_W-1:0]    ALU_IN,
  input  logic [DATA_W-1:0]    SP,
  input  logic [DATA_W-1:0]    mem,
  input  logic                 ld_we,
  input  logic [ADDR_W-1:0]    ld_seg,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 ld_issue,
  input  logic [ADDR_W-1:0]    ld_issue_seg,
  input  logic [ADDR_W-1:0]    rd_seg_A,
  input  logic [ADDR_W-1:0]    rd_seg_B,
  input  logic                 rd_en_A,
  input  logic                 rd_en_B,
  output logic [DATA_W-1:0]    dataout_A,
  output logic [DATA_W-1:0]    dataout_B,
  output logic                 stall,
  output logic [2**ADDR_W-1:0] pend_vec
);

  localparam int unsigned       DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ACC_SEG = ADDR_W'(ACC_IDX);

  logic [DATA_W-1:0] regs [DEPTH];

  logic              pw_en;
  logic [ADDR_W-1:0] pw_seg;
  logic [DATA_W-1:0] pw_data;
  logic [DATA_W-1:0] rd_val_A;
  logic [DATA_W-1:0] rd_val_B;

  always_comb begin
    pw_en   = we;
    pw_seg  = write_seg;
    pw_data = '0;
    case (mux_sel)
      SEL_A:      pw_data = A_in;
      SEL_B:      pw_data = B_in;
      SEL_OR2:    pw_data = OR2;
      SEL_ALU:    pw_data = ALU_IN;
      SEL_SP_ACC: begin pw_data = SP;   pw_seg = ACC_SEG; end
      SEL_B_ACC:  begin pw_data = B_in; pw_seg = ACC_SEG; end
      SEL_MEM:    pw_data = mem;
      default:    pw_en = 1'b0;
    endcase
  end

`ifdef RF_BYPASS_EN
  always_comb begin
    rd_val_A = regs[rd_seg_A];
    rd_val_B = regs[rd_seg_B];
    if (pw_en && pw_seg == rd_seg_A)      rd_val_A = pw_data;
    else if (ld_we && ld_seg == rd_seg_A) rd_val_A = ld_data;
    if (pw_en && pw_seg == rd_seg_B)      rd_val_B = pw_data;
    else if (ld_we && ld_seg == rd_seg_B) rd_val_B = ld_data;
  end
`else
  always_comb begin
    rd_val_A = regs[rd_seg_A];
    rd_val_B = regs[rd_seg_B];
  end
`endif

  // Primary write is issued after the load write so it wins on an index collision.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      dataout_A <= '0;
      dataout_B <= '0;
    end else begin
      if (ld_we) regs[ld_seg] <= ld_data;
      if (pw_en) regs[pw_seg] <= pw_data;
      dataout_A <= rd_val_A;
      dataout_B <= rd_val_B;
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .clr      (clr),
    .set_en   (ld_issue),
    .set_seg  (ld_issue_seg),
    .clr_en   (ld_we),
    .clr_seg  (ld_seg),
    .rd_seg_A (rd_seg_A),
    .rd_en_A  (rd_en_A),
    .rd_seg_B (rd_seg_B),
    .rd_en_B  (rd_en_B),
    .pend     (pend_vec),
    .stall    (stall)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; expectations follow RF_BYPASS_EN when it is defined.
module tb_regfile_sb;

  logic       clk = 1'b0;
  logic       clr, we, ld_we, ld_issue, rd_en_A, rd_en_B, stall;
  logic [2:0] mux_sel, write_seg, ld_seg, ld_issue_seg, rd_seg_A, rd_seg_B;
  logic [7:0] A_in, B_in, OR2, ALU_IN, SP, mem, ld_data, dataout_A, dataout_B, pend_vec;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .ACC_IDX(0)) dut (
    .clk(clk), .clr(clr), .we(we), .mux_sel(mux_sel), .write_seg(write_seg),
    .A_in(A_in), .B_in(B_in), .OR2(OR2), .ALU_IN(ALU_IN), .SP(SP), .mem(mem),
    .ld_we(ld_we), .ld_seg(ld_seg), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_seg(ld_issue_seg),
    .rd_seg_A(rd_seg_A), .rd_seg_B(rd_seg_B), .rd_en_A(rd_en_A), .rd_en_B(rd_en_B),
    .dataout_A(dataout_A), .dataout_B(dataout_B), .stall(stall), .pend_vec(pend_vec)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; ld_we = 0; ld_issue = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      we = 1; mux_sel = 3'b000; write_seg = 3'(i); A_in = 8'(8'h10 + i);
      tick();
    end
    ld_issue = 1; ld_issue_seg = 3'd3;
    tick();
    idle();
    clr = 1; rd_en_A = 1; rd_seg_A = 3'd3; rd_seg_B = 3'd2;
    tick();
    clr = 0;
    checks++; if (dataout_A !== 8'h00) begin errors++; $display("FAIL reset_dout_A got %h want 00", dataout_A); end
    checks++; if (dataout_B !== 8'h00) begin errors++; $display("FAIL reset_dout_B got %h want 00", dataout_B); end
    checks++; if (pend_vec !== 8'h00) begin errors++; $display("FAIL reset_pend got %h want 00", pend_vec); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    rd_en_A = 0; rd_seg_A = 3'd5;
    tick();
    checks++; if (dataout_A !== 8'h00) begin errors++; $display("FAIL reset_r5 got %h want 00", dataout_A); end
  endtask

  task automatic test_mux_codes();
    logic [7:0] exp_v;
    we = 1; mux_sel = 3'b011; write_seg = 3'd3; ALU_IN = 8'h5A; rd_seg_B = 3'd3;
    tick();
    idle();
`ifdef RF_BYPASS_EN
    exp_v = 8'h5A;
`else
    exp_v = 8'h00;
`endif
    checks++; if (dataout_B !== exp_v) begin errors++; $display("FAIL alu_first_edge got %h want %h", dataout_B, exp_v); end
    tick();
    checks++; if (dataout_B !== 8'h5A) begin errors++; $display("FAIL alu_write got %h want 5a", dataout_B); end

    we = 1; mux_sel = 3'b000; write_seg = 3'd2; A_in = 8'h22;
    tick();
    we = 1; mux_sel = 3'b100; write_seg = 3'd2; SP = 8'hF0;
    tick();
    idle(); rd_seg_A = 3'd0; rd_seg_B = 3'd2;
    tick();
    checks++; if (dataout_A !== 8'hF0) begin errors++; $display("FAIL sp_acc got %h want f0", dataout_A); end
    checks++; if (dataout_B !== 8'h22) begin errors++; $display("FAIL sp_acc_seg got %h want 22", dataout_B); end

    we = 1; mux_sel = 3'b111; write_seg = 3'd2;
    A_in = 8'hEE; B_in = 8'hEE; OR2 = 8'hEE; ALU_IN = 8'hEE; SP = 8'hEE; mem = 8'hEE;
    tick();
    idle();
    tick();
    checks++; if (dataout_A !== 8'hF0) begin errors++; $display("FAIL none_acc got %h want f0", dataout_A); end
    checks++; if (dataout_B !== 8'h22) begin errors++; $display("FAIL none_seg got %h want 22", dataout_B); end

    we = 1; mux_sel = 3'b101; write_seg = 3'd2; B_in = 8'h3C;
    tick();
    idle();
    tick();
    checks++; if (dataout_A !== 8'h3C) begin errors++; $display("FAIL b_acc got %h want 3c", dataout_A); end
    checks++; if (dataout_B !== 8'h22) begin errors++; $display("FAIL b_acc_seg got %h want 22", dataout_B); end

    A_in = 8'hA1; B_in = 8'hB2; OR2 = 8'hC3; mem = 8'hD4;
    for (int i = 0; i < 4; i++) begin
      logic [2:0] codes [4];
      logic [7:0] vals [4];
      codes = '{3'b000, 3'b001, 3'b010, 3'b110};
      vals  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      we = 1; mux_sel = codes[i]; write_seg = 3'd5;
      tick();
      idle(); rd_seg_A = 3'd5;
      tick();
      checks++; if (dataout_A !== vals[i]) begin errors++; $display("FAIL src_code%0d got %h want %h", i, dataout_A, vals[i]); end
    end
  endtask

  task automatic test_scoreboard();
    logic [7:0] exp_v;
    ld_issue = 1; ld_issue_seg = 3'd2;
    tick();
    idle(); rd_en_A = 1; rd_seg_A = 3'd2;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall got %b want 1", stall); end
    checks++; if (pend_vec !== 8'h04) begin errors++; $display("FAIL sb_pend got %h want 04", pend_vec); end
    ld_we = 1; ld_seg = 3'd2; ld_data = 8'h33;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_stall_same got %b want 1", stall); end
    tick();
    idle();
`ifdef RF_BYPASS_EN
    exp_v = 8'h33;
`else
    exp_v = 8'h22;
`endif
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_stall_clr got %b want 0", stall); end
    checks++; if (dataout_A !== exp_v) begin errors++; $display("FAIL sb_ld_edge got %h want %h", dataout_A, exp_v); end
    tick();
    checks++; if (dataout_A !== 8'h33) begin errors++; $display("FAIL sb_ld_data got %h want 33", dataout_A); end
    rd_en_A = 0;

    ld_issue = 1; ld_issue_seg = 3'd5;
    tick();
    idle(); rd_en_B = 0; rd_seg_B = 3'd5;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_no_en got %b want 0", stall); end
    rd_en_B = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_en_B got %b want 1", stall); end
    ld_we = 1; ld_seg = 3'd5; ld_data = 8'h55;
    tick();
    idle(); rd_en_B = 0;
    checks++; if (pend_vec !== 8'h00) begin errors++; $display("FAIL sb_pend_clr got %h want 00", pend_vec); end
  endtask

  task automatic test_conflicts();
    ld_issue = 1; ld_issue_seg = 3'd4;
    tick();
    idle();
    we = 1; mux_sel = 3'b000; write_seg = 3'd4; A_in = 8'h11;
    ld_we = 1; ld_seg = 3'd4; ld_data = 8'h22;
    tick();
    idle(); rd_seg_A = 3'd4;
    checks++; if (pend_vec[4] !== 1'b0) begin errors++; $display("FAIL conf_pend4 got %b want 0", pend_vec[4]); end
    tick();
    checks++; if (dataout_A !== 8'h11) begin errors++; $display("FAIL conf_r4 got %h want 11", dataout_A); end

    ld_issue = 1; ld_issue_seg = 3'd6; ld_we = 1; ld_seg = 3'd6; ld_data = 8'h44;
    tick();
    idle();
    checks++; if (pend_vec !== 8'h40) begin errors++; $display("FAIL conf_set_wins got %h want 40", pend_vec); end

    we = 1; mux_sel = 3'b000; write_seg = 3'd6; A_in = 8'h5E;
    tick();
    idle(); rd_seg_A = 3'd6;
    checks++; if (pend_vec !== 8'h40) begin errors++; $display("FAIL waw_pend got %h want 40", pend_vec); end
    tick();
    checks++; if (dataout_A !== 8'h5E) begin errors++; $display("FAIL waw_data got %h want 5e", dataout_A); end
    ld_we = 1; ld_seg = 3'd6; ld_data = 8'h66;
    tick();
    idle();
    tick();
    checks++; if (dataout_A !== 8'h66) begin errors++; $display("FAIL waw_load got %h want 66", dataout_A); end
    checks++; if (pend_vec !== 8'h00) begin errors++; $display("FAIL waw_pend_clr got %h want 00", pend_vec); end
  endtask

  task automatic test_bypass();
    logic [7:0] e1, e2;
    we = 1; mux_sel = 3'b000; write_seg = 3'd1; A_in = 8'h00;
    tick();
    rd_seg_A = 3'd1; A_in = 8'h7E;
    tick();
    idle();
`ifdef RF_BYPASS_EN
    e1 = 8'h7E;
`else
    e1 = 8'h00;
`endif
    checks++; if (dataout_A !== e1) begin errors++; $display("FAIL byp_pw got %h want %h", dataout_A, e1); end
    tick();
    checks++; if (dataout_A !== 8'h7E) begin errors++; $display("FAIL byp_pw_late got %h want 7e", dataout_A); end

    ld_we = 1; ld_seg = 3'd1; ld_data = 8'h19;
    tick();
    idle();
`ifdef RF_BYPASS_EN
    e1 = 8'h19;
`else
    e1 = 8'h7E;
`endif
    checks++; if (dataout_A !== e1) begin errors++; $display("FAIL byp_ld got %h want %h", dataout_A, e1); end

    we = 1; mux_sel = 3'b000; write_seg = 3'd1; A_in = 8'h2B;
    ld_we = 1; ld_seg = 3'd1; ld_data = 8'h4C;
    tick();
    idle();
`ifdef RF_BYPASS_EN
    e2 = 8'h2B;
`else
    e2 = 8'h19;
`endif
    checks++; if (dataout_A !== e2) begin errors++; $display("FAIL byp_prio got %h want %h", dataout_A, e2); end
    tick();
    checks++; if (dataout_A !== 8'h2B) begin errors++; $display("FAIL byp_prio_late got %h want 2b", dataout_A); end
  endtask

  task automatic test_reset_midload();
    ld_issue = 1; ld_issue_seg = 3'd7;
    tick();
    idle(); clr = 1; rd_seg_B = 3'd7; rd_en_B = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ml_stall_pre got %b want 1", stall); end
    tick();
    clr = 0;
    checks++; if (pend_vec !== 8'h00) begin errors++; $display("FAIL ml_pend got %h want 00", pend_vec); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ml_stall got %b want 0", stall); end

    clr = 1; ld_issue = 1; ld_issue_seg = 3'd3;
    we = 1; mux_sel = 3'b000; write_seg = 3'd7; A_in = 8'h99;
    tick();
    clr = 0; idle();
    checks++; if (pend_vec !== 8'h00) begin errors++; $display("FAIL ml_clr_over got %h want 00", pend_vec); end
    tick();
    checks++; if (dataout_B !== 8'h00) begin errors++; $display("FAIL ml_clr_we got %h want 00", dataout_B); end

    ld_we = 1; ld_seg = 3'd7; ld_data = 8'h77;
    tick();
    idle();
    tick();
    checks++; if (dataout_B !== 8'h77) begin errors++; $display("FAIL ml_ld_after got %h want 77", dataout_B); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ml_stall_after got %b want 0", stall); end
    rd_en_B = 0;
  endtask

  initial begin
    clr = 1; idle();
    mux_sel = 3'b111; write_seg = '0; ld_seg = '0; ld_issue_seg = '0;
    rd_seg_A = '0; rd_seg_B = '0; rd_en_A = 0; rd_en_B = 0;
    A_in = '0; B_in = '0; OR2 = '0; ALU_IN = '0; SP = '0; mem = '0; ld_data = '0;
    tick();
    tick();
    clr = 0;
    test_reset();
    test_mux_codes();
    test_scoreboard();
    test_conflicts();
    test_bypass();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 8-bit dual-port register file.
- Keeps the write-source mux used by the control unit.
- Adds two freely addressed registered read ports, a second write port for late load data, and a per-register pending scoreboard that flags read hazards.
- Sits between the decoder/control FSM and the ALU operand latches.

Parameters:
- DATA_W, 8: register and data-path width in bits.
- ADDR_W, 3: register index width; depth = 2**ADDR_W.
- ACC_IDX, 0: index of the accumulator, the fixed destination for mux codes 100/101.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr  in  1  synchronous active-high reset/clear.
- we  in  1  primary write enable.
- mux_sel  in  3  primary write-source select.
- write_seg  in  ADDR_W  primary write index.
- A_in, B_in, OR2, ALU_IN, SP, mem  in  DATA_W each  primary write sources.
- ld_we  in  1  load-writeback write enable (second write port).
- ld_seg  in  ADDR_W  load-writeback index.
- ld_data  in  DATA_W  load-writeback data.
- ld_issue  in  1  load issued; marks ld_issue_seg pending.
- ld_issue_seg  in  ADDR_W  destination of the issued load.
- rd_seg_A, rd_seg_B  in  ADDR_W  read indices.
- rd_en_A, rd_en_B  in  1  read port in use (for hazard detection).
- dataout_A, dataout_B  out  DATA_W  registered read data.
- stall  out  1  combinational read hazard.
- pend_vec  out  2**ADDR_W  current pending bits.

Behaviour:
- Primary write path, mux_sel codes (we=1):
  - 000: R[write_seg] <= A_in
  - 001: R[write_seg] <= B_in
  - 010: R[write_seg] <= OR2
  - 011: R[write_seg] <= ALU_IN
  - 100: R[ACC_IDX] <= SP
  - 101: R[ACC_IDX] <= B_in
  - 110: R[write_seg] <= mem
  - 111: no write (reserved)
  - All writes are nonblocking.
- Load port: ld_we=1 gives R[ld_seg] <= ld_data and clears pend[ld_seg].
- Write conflict: primary and load port writing the same index in one cycle → primary data wins; pend is still cleared.
- Reads:
  - dataout_A <= R[rd_seg_A] and dataout_B <= R[rd_seg_B] every cycle.
  - One-cycle latency, unconditional, no enable gating.
- Scoreboard:
  - ld_issue=1 sets pend[ld_issue_seg] at the next edge.
  - Set and clear of the same index in one cycle → set wins (new load outstanding).
- WAW on a pending register: a primary write to a pending index writes the data; pend stays set, so the later load overwrites it.
- stall = (rd_en_A & pend[rd_seg_A]) | (rd_en_B & pend[rd_seg_B]).
  - Combinational, derived from the registered pend state.
  - Same-cycle ld_we does not clear stall until the next cycle.
- Reset (clr=1 at posedge):
  - All R, pend_vec, dataout_A and dataout_B go to 0; stall goes to 0.
  - clr overrides we, ld_we and ld_issue in the same cycle, including mid-load: the outstanding load is forgotten.
  - A subsequent ld_we still writes normally.
- Widths: no arithmetic. Indices use the full ADDR_W with no wrap logic. Source buses must be exactly DATA_W wide.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Write-to-read forwarding. If rd_seg_X matches an index written this cycle, dataout_X takes the new value at the same edge.
  - Forwarding priority is primary write over load port.
  - For codes 100/101, ACC_IDX is the matched index.
- Undefined: reads return the pre-write value, read-old-data behaviour.
- stall logic is identical in both builds.

Decomposition:
- Package rf_pkg holds:
  - mux_sel code localparams (SEL_A, SEL_B, SEL_OR2, SEL_ALU, SEL_SP_ACC, SEL_B_ACC, SEL_MEM, SEL_NONE).
  - Default DATA_W/ADDR_W.
- Sub-module rf_scoreboard holds:
  - pend register with set/clear priority and clr handling.
  - stall generation.
- Register array, source mux and read/bypass logic stay in regfile_sb.

Test Plan:
1. Reset: clr=1 after random writes → next cycle all dataout=0, pend_vec=0, stall=0; read R5 → 0x00.
2. Mux codes:
   - we=1, mux_sel=011, write_seg=3, ALU_IN=0x5A, then read rd_seg_B=3 → dataout_B=0x5A two edges after the write.
   - mux_sel=100, SP=0xF0 → R0=0xF0, R[write_seg] unchanged.
   - mux_sel=111 → no register changes.
3. Scoreboard:
   - ld_issue, ld_issue_seg=2; then rd_en_A=1, rd_seg_A=2 → stall=1.
   - ld_we, ld_seg=2, ld_data=0x33 → stall=0 next cycle; dataout_A=0x33 one cycle later.
4. Conflicts:
   - Same-cycle we (code 000, seg 4, A_in=0x11) and ld_we (seg 4, 0x22) → R4=0x11, pend[4]=0.
   - Same-cycle ld_issue and ld_we on seg 6 → pend[6]=1.
5. Bypass:
   - rd_seg_A=1 while writing R1 0x00→0x7E.
   - With RF_BYPASS_EN: dataout_A=0x7E at that edge.
   - Without: dataout_A=0x00, then 0x7E a cycle later.
6. Reset mid-load: ld_issue seg 7, clr=1 next cycle → pend_vec=0, stall=0 with rd_seg_B=7, rd_en_B=1.
